ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream stage of the input decoder. Receives PS/2 keyboard frames (scan code set 2), validates them, and tracks E0/F0 prefixes.
- Converts key make-codes into single-cycle 4-bit command codes on inCode.
- Between commands, inCode holds the idle code 4'hF, so every downstream action (size step, toggles) fires exactly once per key press or typematic repeat.

Parameters:
- FILTER_LEN, 8: number of consecutive system clocks the synchronised ps2Clk must hold a new level before the level is accepted.
- TIMEOUT, 100000: system clocks allowed between PS/2 clock falling edges inside a frame before the frame is aborted.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2Clk  in  1  raw PS/2 clock; asynchronous to clock.
- ps2Data  in  1  raw PS/2 data; asynchronous to clock.
- inCode  out  4  command code; 4'hF when idle.
- codeValid  out  1  high for exactly the one cycle in which inCode holds a command (not 4'hF).
- frameErr  out  1  one-cycle pulse on a parity error, stop-bit error, or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - inCode=4'hF, codeValid=0, frameErr=0.
  - FSM goes to IDLE; ext and brk flags clear; filter and timeout counters clear.
  - Synchroniser flops preset to 1.
- Input conditioning:
  - Two-flop synchroniser on each of ps2Clk and ps2Data.
  - Clock filter: the filtered clock changes only after FILTER_LEN consecutive equal samples that differ from its current value.
  - A falling edge of the filtered clock is the sample event; ps2Data (synchronised) is sampled on that same cycle.
- Receive FSM, advancing only on sample events:
  - IDLE: if data=0, go to DATA with bitCnt=0; if data=1, stay in IDLE (spurious edge).
  - DATA: shift data in LSB-first; after 8 bits go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: the frame is good if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity).
    - Good frame: issue the byte to the byte handler.
    - Bad frame: pulse frameErr.
    - In both cases return to IDLE.
- Timeout:
  - The counter resets on every sample event and counts only outside IDLE.
  - On reaching TIMEOUT: pulse frameErr, discard the partial byte, go to IDLE. ext and brk are retained.
- Byte handler, acting on the cycle after the stop bit is sampled:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte is looked up, then ext and brk are both cleared.
  - If brk was set (key release), nothing is emitted.
- Make-code map (ext=0):
  - Digits: 45→0, 16→1, 1E→2, 26→3.
  - Colours: 2D(R)→4, 34(G)→5, 32(B)→6.
  - Size: 79(KP+)→B, 7B(KP-)→C.
  - Toggles: 42(K)→D, 2B(F)→E.
- Make-code map (ext=1): 75(Up)→7, 72(Down)→8, 6B(Left)→9, 74(Right)→A.
- Unmapped bytes: flags clear, nothing is emitted.
- Emission timing:
  - A mapped make-code drives inCode=code and codeValid=1 for exactly one cycle, two clocks after the STOP sample event.
  - The following cycle, inCode returns to 4'hF.
  - Typematic repeats are full make-code frames and emit again.
- An error frame does not modify ext or brk.
- An E0 followed by an unmapped non-extended code clears ext.
- Reset asserted mid-frame: asynchronous return to the reset state; the frame is lost, no output.

Test Plan:
- Reset low, then high, with ps2 lines idle high → inCode=4'hF, codeValid=0 indefinitely; a single edge with data=1 leaves the FSM in IDLE.
- Frame 8'h16 with parity 0 and stop 1 → exactly one cycle of inCode=4'h1 with codeValid=1, two clocks after the STOP edge; then 4'hF.
- Sequence E0,75 then E0,F0,75 → one pulse inCode=4'h7; the release sequence produces no pulse.
- Frame 8'h79 with a wrong parity bit (1) → frameErr pulses once, no codeValid; the next valid 8'h79 frame → inCode=4'hB pulse.
- Start bit plus 4 data bits, then ps2Clk held high for TIMEOUT+1 clocks → frameErr pulse and return to IDLE; a subsequent 8'h2D frame → inCode=4'h4 pulse.
- A 3-clock low glitch on ps2Clk with FILTER_LEN=8 → no bit sampled; reset dropped mid-frame → outputs at reset values immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: conditions the raw PS/2 lines, receives scan code
// set 2 frames, tracks E0/F0 prefixes and turns make-codes into one-cycle
// 4-bit command codes (4'hF when idle).
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [3:0] inCode,
    output logic       codeValid,
    output logic       frameErr
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          filtClk;
    logic          filtClkD;
    logic [FW-1:0] filtCnt;
    logic          sampleEv;
    logic          dataS;

    logic [1:0]    state;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] toCnt;
    logic          byteStb;
    logic [7:0]    rxByte;

    logic          ext;
    logic          brk;
    logic          lookupHit;
    logic [3:0]    lookupCode;

    // Two-flop synchronisers, preset high so idle lines look idle out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
        end
    end

    // Glitch filter: accept a new clock level only after FILTER_LEN equal samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtClk  <= 1'b1;
            filtClkD <= 1'b1;
            filtCnt  <= '0;
        end else begin
            filtClkD <= filtClk;
            if (clkSync[1] == filtClk) begin
                filtCnt <= '0;
            end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
                filtClk <= clkSync[1];
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

    // Sample event is the cycle right after the filtered clock has fallen;
    // data is taken from the synchroniser in that same cycle.
    assign sampleEv = filtClkD & ~filtClk;
    assign dataS    = dataSync[1];

    // Frame receiver with inter-edge timeout; good bytes strobe the handler
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
            byteStb   <= 1'b0;
            rxByte    <= '0;
            frameErr  <= 1'b0;
        end else begin
            byteStb  <= 1'b0;
            frameErr <= 1'b0;
            if (sampleEv) begin
                toCnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dataS) begin
                            state  <= DATA;
                            bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        shiftReg <= {dataS, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parityBit <= dataS;
                        state     <= STOP;
                    end
                    default: begin
                        if (dataS && (^{shiftReg, parityBit})) begin
                            byteStb <= 1'b1;
                            rxByte  <= shiftReg;
                        end else begin
                            frameErr <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (toCnt == TW'(TIMEOUT - 1)) begin
                    frameErr <= 1'b1;
                    state    <= IDLE;
                    toCnt    <= '0;
                end else begin
                    toCnt <= toCnt + 1'b1;
                end
            end else begin
                toCnt <= '0;
            end
        end
    end

    // Make-code lookup, keyed on the extended flag and the received byte
    always_comb begin
        lookupHit  = 1'b1;
        lookupCode = 4'hF;
        case ({ext, rxByte})
            9'h045: lookupCode = 4'h0;
            9'h016: lookupCode = 4'h1;
            9'h01E: lookupCode = 4'h2;
            9'h026: lookupCode = 4'h3;
            9'h02D: lookupCode = 4'h4;
            9'h034: lookupCode = 4'h5;
            9'h032: lookupCode = 4'h6;
            9'h079: lookupCode = 4'hB;
            9'h07B: lookupCode = 4'hC;
            9'h042: lookupCode = 4'hD;
            9'h02B: lookupCode = 4'hE;
            9'h175: lookupCode = 4'h7;
            9'h172: lookupCode = 4'h8;
            9'h16B: lookupCode = 4'h9;
            9'h174: lookupCode = 4'hA;
            default: lookupHit = 1'b0;
        endcase
    end

    // Byte handler: prefix tracking and one-cycle command emission
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            inCode    <= 4'hF;
            codeValid <= 1'b0;
        end else begin
            inCode    <= 4'hF;
            codeValid <= 1'b0;
            if (byteStb) begin
                if (rxByte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rxByte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!brk && lookupHit) begin
                        inCode    <= lookupCode;
                        codeValid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random frames, checked
// against a prefix/keymap model of the scan code rules.
module tb_ps2_key_decoder;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 300;
    localparam int          HALF = 20;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2Clk  = 1'b1;
    logic       ps2Data = 1'b1;
    logic [3:0] inCode;
    logic       codeValid;
    logic       frameErr;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .inCode    (inCode),
        .codeValid (codeValid),
        .frameErr  (frameErr)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int asserts = 0;
    int fails   = 0;

    logic [3:0]  gotQ[$];
    int unsigned gotCyc[$];
    int          errCnt  = 0;
    int          badIdle = 0;
    int unsigned lastFall = 0;

    // Output monitor, sampled on the falling clock edge
    always @(negedge clock) begin
        if (codeValid === 1'b1) begin
            gotQ.push_back(inCode);
            gotCyc.push_back(cyc);
            if (inCode === 4'hF) badIdle++;
        end else if (inCode !== 4'hF) begin
            badIdle++;
        end
        if (frameErr === 1'b1) errCnt++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference model: prefix flags and keymap keyed by {ext, byte}
    bit         mExt = 1'b0;
    bit         mBrk = 1'b0;
    logic [3:0] codeMap [int];
    logic [7:0] pool [15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34, 8'h32,
                              8'h79, 8'h7B, 8'h42, 8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic d, input bit glitch);
        ps2Data = d;
        repeat (HALF / 2) @(negedge clock);
        if (glitch) begin
            ps2Clk = 1'b0;
            repeat (3) @(negedge clock);
            ps2Clk = 1'b1;
        end
        repeat (HALF / 2) @(negedge clock);
        ps2Clk   = 1'b0;
        lastFall = cyc;
        repeat (HALF) @(negedge clock);
        ps2Clk = 1'b1;
    endtask

    task automatic sendBits(input logic [7:0] b, input bit badPar, input bit badStop,
                            input int nBits, input int glitchBit);
        logic [10:0] f;
        f = {~badStop, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nBits; i++) sendBit(f[i], i == glitchBit);
        ps2Data = 1'b1;
    endtask

    task automatic doFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                           input int glitchBit);
        int         n0 = gotQ.size();
        int         e0 = errCnt;
        bit         expHit = 1'b0;
        logic [3:0] expCode = 4'hF;
        int         expErr = 0;
        if (badPar || badStop) begin
            expErr = 1;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (b == 8'hF0) begin
            mBrk = 1'b1;
        end else begin
            if (!mBrk && codeMap.exists(int'({mExt, b}))) begin
                expHit  = 1'b1;
                expCode = codeMap[int'({mExt, b})];
            end
            mExt = 1'b0;
            mBrk = 1'b0;
        end
        sendBits(b, badPar, badStop, 11, glitchBit);
        repeat (40) @(negedge clock);
        chk($sformatf("pulses_%02h", b), gotQ.size() - n0, expHit);
        if (expHit && gotQ.size() > n0) begin
            chk($sformatf("code_%02h", b), gotQ[n0], expCode);
            chk($sformatf("latency_%02h", b),
                (gotCyc[n0] - lastFall) inside {[FL + 2 : FL + 6]}, 1);
        end
        chk($sformatf("frameErr_%02h", b), errCnt - e0, expErr);
        chk("idleCode", badIdle, 0);
    endtask

    initial begin
        int         n0;
        int         e0;
        int         r;
        logic [7:0] b;

        codeMap['h045] = 4'h0; codeMap['h016] = 4'h1; codeMap['h01E] = 4'h2;
        codeMap['h026] = 4'h3; codeMap['h02D] = 4'h4; codeMap['h034] = 4'h5;
        codeMap['h032] = 4'h6; codeMap['h079] = 4'hB; codeMap['h07B] = 4'hC;
        codeMap['h042] = 4'hD; codeMap['h02B] = 4'hE;
        codeMap['h175] = 4'h7; codeMap['h172] = 4'h8;
        codeMap['h16B] = 4'h9; codeMap['h174] = 4'hA;

        // Reset and idle
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_inCode", inCode, 4'hF);
        chk("rst_codeValid", codeValid, 0);
        chk("rst_frameErr", frameErr, 0);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        chk("idle_pulses", gotQ.size(), 0);
        chk("idle_errs", errCnt, 0);
        chk("idle_inCode", inCode, 4'hF);

        // Spurious edge with data high, then a clean frame
        ps2Data = 1'b1;
        ps2Clk  = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2Clk = 1'b1;
        repeat (HALF) @(negedge clock);
        doFrame(8'h16, 0, 0, -1);

        // Extended make, then extended release
        doFrame(8'hE0, 0, 0, -1);
        doFrame(8'h75, 0, 0, -1);
        doFrame(8'hE0, 0, 0, -1);
        doFrame(8'hF0, 0, 0, -1);
        doFrame(8'h75, 0, 0, -1);

        // Parity error then good frame
        doFrame(8'h79, 1, 0, -1);
        doFrame(8'h79, 0, 0, -1);

        // Typematic repeat and stop-bit error
        doFrame(8'h16, 0, 0, -1);
        doFrame(8'h16, 0, 0, -1);
        doFrame(8'h2B, 0, 1, -1);

        // E0 followed by an unmapped byte clears ext
        doFrame(8'hE0, 0, 0, -1);
        doFrame(8'h1C, 0, 0, -1);
        doFrame(8'h75, 0, 0, -1);

        // Error frame keeps ext
        doFrame(8'hE0, 0, 0, -1);
        doFrame(8'h75, 1, 0, -1);
        doFrame(8'h75, 0, 0, -1);

        // Timeout mid-frame
        n0 = gotQ.size();
        e0 = errCnt;
        sendBits(8'h2D, 0, 0, 5, -1);
        repeat (TO + 40) @(negedge clock);
        chk("timeout_err", errCnt - e0, 1);
        chk("timeout_pulses", gotQ.size() - n0, 0);
        doFrame(8'h2D, 0, 0, -1);

        // Short clock glitch is filtered out
        doFrame(8'h42, 0, 0, 3);

        // Reset mid-frame clears outputs and prefixes
        doFrame(8'hE0, 0, 0, -1);
        sendBits(8'h75, 0, 0, 4, -1);
        reset = 1'b0;
        #1;
        chk("midrst_inCode", inCode, 4'hF);
        chk("midrst_codeValid", codeValid, 0);
        chk("midrst_frameErr", frameErr, 0);
        mExt    = 1'b0;
        mBrk    = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        doFrame(8'h75, 0, 0, -1);
        doFrame(8'h26, 0, 0, -1);

        // Random frames
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(99);
            if (r < 40)      b = pool[$urandom_range(14)];
            else if (r < 55) b = 8'hE0;
            else if (r < 70) b = 8'hF0;
            else             b = 8'($urandom);
            doFrame(b, $urandom_range(9) == 0, $urandom_range(19) == 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
